// File: rtl/pcie_mmio_rsp_pkg.sv
// Shared types and constants for the MMIO completer: completion status and
// error codes, request/completion records and the byte-count helper.
package pcie_mmio_rsp_pkg;

    localparam logic [2:0] CPL_SC = 3'd0;
    localparam logic [2:0] CPL_UR = 3'd1;
    localparam logic [2:0] CPL_CA = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_WR  = 2'd1;
    localparam logic [1:0] ERR_BAD_LEN = 2'd2;
    localparam logic [1:0] ERR_CPL_TO  = 2'd3;

    typedef enum logic {S_IDLE, S_CPL} t_state;

    typedef struct packed {
        logic        wr;
        logic [1:0]  len;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [15:0] cid;
        logic [6:0]  lower_addr;
        logic [63:0] data;
    } t_mmio_req;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [15:0] cid;
        logic [2:0]  status;
        logic [6:0]  lower_addr;
        logic [11:0] byte_cnt;
        logic [63:0] data;
    } t_mmio_cpl;

    function automatic logic [11:0] byte_cnt(input logic [1:0] len);
        return {8'd0, len, 2'b00};
    endfunction

endpackage

// File: rtl/mmio_regfile.sv
// REG_DEPTH x 64-bit CSR storage with per-half write enables and a
// combinational read port. CSR 0 is a read-only ID register.
module mmio_regfile #(
    parameter int          REG_DEPTH = 16,
    parameter logic [63:0] CSR_ID    = 64'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_lo_en,
    input  logic                         wr_hi_en,
    input  logic [$clog2(REG_DEPTH)-1:0] wr_idx,
    input  logic [63:0]                  wr_data,
    input  logic [$clog2(REG_DEPTH)-1:0] rd_idx,
    output logic [63:0]                  rd_data
);
    localparam int IDX_W = $clog2(REG_DEPTH);

    logic [63:0] regs_q [REG_DEPTH];

    // Index 0 is loaded with the ID on reset and has no write path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q[0] <= CSR_ID;
            for (int i = 1; i < REG_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    if (wr_lo_en) regs_q[i][31:0]  <= wr_data[31:0];
                    if (wr_hi_en) regs_q[i][63:32] <= wr_data[63:32];
                end
            end
        end
    end

    assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/mmio_cpl_responder.sv
// MMIO completer: applies decoded requests to the CSR file and returns tagged
// completions for reads. Optional stall timeout via CPL_STALL_TIMEOUT_EN.
import pcie_mmio_rsp_pkg::*;

module mmio_cpl_responder #(
    parameter int          REG_DEPTH = 16,
    parameter logic [63:0] CSR_ID    = 64'h0,
    parameter int          ADDR_W    = 20,
    parameter int          TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_len,
    input  logic [7:0]        i_req_tag,
    input  logic [15:0]       i_req_rid,
    input  logic [15:0]       i_req_cid,
    input  logic [63:0]       i_req_data,
    output logic              o_cpl_valid,
    input  logic              i_cpl_ready,
    output logic [7:0]        o_cpl_tag,
    output logic [15:0]       o_cpl_rid,
    output logic [15:0]       o_cpl_cid,
    output logic [2:0]        o_cpl_status,
    output logic [6:0]        o_cpl_lower_addr,
    output logic [11:0]       o_cpl_byte_cnt,
    output logic [63:0]       o_cpl_data,
    output logic              o_err_valid,
    output logic [1:0]        o_err_code
);
    localparam int                IDX_W     = $clog2(REG_DEPTH);
    localparam logic [ADDR_W-1:0] RANGE_END = ADDR_W'(REG_DEPTH * 8);

    if (REG_DEPTH < 2 || REG_DEPTH > 256 || TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_cfg
        $error("mmio_cpl_responder: REG_DEPTH or TO_CYCLES out of range");
    end

    t_state      state_q, state_d;
    t_mmio_cpl   cpl_q, cpl_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;
    t_mmio_req   req;
    logic [IDX_W-1:0] idx;
    logic        in_range, len_ok, misalign, wr_ok;
    logic        wr_lo_en, wr_hi_en;
    logic [63:0] rf_rd;
    logic [31:0] sel_half;
    logic [2:0]  rd_status;
`ifdef CPL_STALL_TIMEOUT_EN
    logic [7:0]  to_cnt_q, to_cnt_d;
`endif

    assign req = '{wr: i_req_wr, len: i_req_len, tag: i_req_tag, rid: i_req_rid,
                   cid: i_req_cid, lower_addr: i_req_addr[6:0], data: i_req_data};

    assign idx      = i_req_addr[3 +: IDX_W];
    assign in_range = (i_req_addr < RANGE_END);
    assign len_ok   = (req.len == 2'd1) || (req.len == 2'd2);
    assign misalign = (req.len == 2'd2) && i_req_addr[2];
    assign wr_ok    = in_range && (idx != '0) && len_ok && !misalign;
    assign sel_half = i_req_addr[2] ? rf_rd[63:32] : rf_rd[31:0];

    always_comb begin
        rd_status = CPL_SC;
        if (!len_ok)        rd_status = CPL_CA;
        else if (!in_range) rd_status = CPL_UR;
        else if (misalign)  rd_status = CPL_CA;
    end

    // A 1-DW write replicates DW0 so either half can take it.
    mmio_regfile #(
        .REG_DEPTH (REG_DEPTH),
        .CSR_ID    (CSR_ID)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_lo_en (wr_lo_en),
        .wr_hi_en (wr_hi_en),
        .wr_idx   (idx),
        .wr_data  ((req.len == 2'd1) ? {req.data[31:0], req.data[31:0]} : req.data),
        .rd_idx   (idx),
        .rd_data  (rf_rd)
    );

    always_comb begin
        state_d     = state_q;
        cpl_d       = cpl_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        wr_lo_en    = 1'b0;
        wr_hi_en    = 1'b0;
`ifdef CPL_STALL_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (req.wr) begin
                        if (wr_ok) begin
                            wr_lo_en = (req.len == 2'd2) || !i_req_addr[2];
                            wr_hi_en = (req.len == 2'd2) || i_req_addr[2];
                        end else begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_BAD_WR;
                        end
                    end else begin
                        state_d          = S_CPL;
                        cpl_d.tag        = req.tag;
                        cpl_d.rid        = req.rid;
                        cpl_d.cid        = req.cid;
                        cpl_d.status     = rd_status;
                        cpl_d.lower_addr = req.lower_addr;
                        cpl_d.byte_cnt   = byte_cnt(req.len);
                        cpl_d.data       = '0;
                        if (rd_status == CPL_SC) begin
                            cpl_d.data = (req.len == 2'd2) ? rf_rd : {32'd0, sel_half};
                        end
                        if (!len_ok) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_BAD_LEN;
                        end
`ifdef CPL_STALL_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_CPL: begin
                if (i_cpl_ready) begin
                    state_d = S_IDLE;
                end
`ifdef CPL_STALL_TIMEOUT_EN
                else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    if (to_cnt_d == 8'(TO_CYCLES)) begin
                        state_d     = S_IDLE;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CPL_TO;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cpl_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef CPL_STALL_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cpl_q       <= cpl_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
`ifdef CPL_STALL_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign o_req_ready      = (state_q == S_IDLE);
    assign o_cpl_valid      = (state_q == S_CPL);
    assign o_cpl_tag        = cpl_q.tag;
    assign o_cpl_rid        = cpl_q.rid;
    assign o_cpl_cid        = cpl_q.cid;
    assign o_cpl_status     = cpl_q.status;
    assign o_cpl_lower_addr = cpl_q.lower_addr;
    assign o_cpl_byte_cnt   = cpl_q.byte_cnt;
    assign o_cpl_data       = cpl_q.data;
    assign o_err_valid      = err_valid_q;
    assign o_err_code       = err_code_q;

endmodule

// File: doc/mmio_cpl_responder.md
# mmio_cpl_responder

Synthesizable MMIO completer at the device end of the host MMIO path. It consumes decoded memory read/write requests, which the root-port tester issues as tagged MMIO TLPs, and applies them to a small 64-bit CSR file. For each read it returns a tagged completion carrying requester ID, completer ID, lower address, byte count and status, which is exactly what the tester's tag-tracking completion checker validates. It sits between the PCIe RX request demux and the TX completion arbiter.

## Interface
- REG_DEPTH, 16: number of 64-bit CSRs; power of two, 2..256
- CSR_ID, 64'h0: read-only value of CSR 0
- ADDR_W, 20: request byte-address width
- TO_CYCLES, 255: completion-stall timeout; used only with CPL_STALL_TIMEOUT_EN
- clk  in  1  clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous and active-high
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accept
- i_req_wr  in  1  1 = memory write (posted), 0 = memory read
- i_req_addr  in  ADDR_W  byte address
- i_req_len  in  2  length in DW; only 1 or 2 are legal
- i_req_tag  in  8  request tag
- i_req_rid  in  16  requester ID
- i_req_cid  in  16  completer ID: {vfn[11:0], vf_active, pfn[2:0]}
- i_req_data  in  64  write data; DW0 is in [31:0]
- o_cpl_valid  out  1  completion valid
- i_cpl_ready  in  1  completion accept
- o_cpl_tag  out  8  completion tag
- o_cpl_rid  out  16  completion requester ID
- o_cpl_cid  out  16  completion completer ID
- o_cpl_status  out  3  0 = SC, 1 = UR, 4 = CA
- o_cpl_lower_addr  out  7  i_req_addr[6:0]
- o_cpl_byte_cnt  out  12  byte count, len × 4
- o_cpl_data  out  64  completion data; zero unless status is SC
- o_err_valid  out  1  one-cycle error pulse
- o_err_code  out  2  1 = bad write, 2 = illegal length, 3 = completion timeout

## Operation
- States are IDLE and CPL. o_req_ready = (state == IDLE).
- Address decode:
  - Index = i_req_addr[3 +: log2(REG_DEPTH)].
  - The address is in range when i_req_addr < REG_DEPTH × 8.
  - A 1-DW access selects the upper half when addr[2] = 1, otherwise the lower half.
- Write, IDLE:
  - Legal write: update the register (or selected half) and stay in IDLE. No completion is generated.
  - Dropped writes, each pulsing o_err_valid with code 1:
    - CSR 0, which is read-only;
    - out-of-range address;
    - len = 2 with addr[2] = 1;
    - len = 0 or 3.
- Read, IDLE: latch the completion fields and go to CPL. Status is chosen as follows:
  - len = 0 or 3: CA, plus an error pulse with code 2.
  - Otherwise, out-of-range address: UR.
  - Otherwise, len = 2 with addr[2] = 1: CA.
  - Otherwise: SC.
- Read data:
  - 1-DW reads return the selected half in o_cpl_data[31:0]; [63:32] is zero.
  - 2-DW reads return the full register.
- CPL: hold every o_cpl_* field stable until i_cpl_ready is high, then return to IDLE.

## Timing
- Reset values: o_cpl_valid = 0, o_err_valid = 0, o_err_code = 0, all o_cpl_* fields = 0, every CSR = 0 except CSR 0 = CSR_ID. o_req_ready = 1 once rst is low.
- Read latency: request accepted at cycle n, o_cpl_valid high at cycle n+1.
- Read throughput: a completion accepted at cycle m lets the next request be accepted at m+1. Peak is one read every 2 cycles.
- Writes are accepted every cycle. A write accepted at cycle n is visible to a read accepted at n+1.
- o_err_valid is asserted in the cycle after the offending request is accepted.
- Asserting rst mid-completion drops the in-flight completion immediately (o_cpl_valid goes to 0) and restores reset values.

## Configuration
- CPL_STALL_TIMEOUT_EN defined:
  - An 8-bit counter runs while in CPL with i_cpl_ready low.
  - When the count reaches TO_CYCLES, the completion is dropped: o_cpl_valid goes to 0, o_err_valid pulses with code 3, and the block returns to IDLE.
  - The counter clears on every entry to CPL.
- CPL_STALL_TIMEOUT_EN undefined: no counter; a completion waits indefinitely; code 3 is never generated.

## Structure
- In the shared package pcie_mmio_rsp_pkg:
  - completion status constants CPL_SC, CPL_UR, CPL_CA;
  - error code constants;
  - structs t_mmio_req and t_mmio_cpl;
  - function byte_cnt(len).
- One sub-module, mmio_regfile:
  - REG_DEPTH × 64-bit storage with per-half write enables;
  - combinational read port;
  - read-only handling of CSR 0.
- The FSM and completion formatting live in the top level.

## Test plan
- Write CSR 3 at 0x18 with 64'hDEAD_BEEF_0123_4567 (len = 2), then read it back with tag 5 and RID 0x0100 → completion status 0, data DEAD_BEEF_0123_4567, byte_cnt 8, lower_addr 0x18, tag 5, RID 0x0100.
- 1-DW read at 0x1C → data 0x0000_0000_DEAD_BEEF, byte_cnt 4.
- Read at address REG_DEPTH × 8 → status 1 (UR), data 0. Write to 0x0 → o_err_valid with code 1, and a following read of CSR 0 returns CSR_ID.
- Read with len = 2 at 0x0C → status 4 (CA).
- Hold i_cpl_ready low for 20 cycles after a read → fields stable and o_req_ready = 0 throughout; completion accepted at the first ready cycle; a new request accepted the next cycle.
- With CPL_STALL_TIMEOUT_EN defined, hold i_cpl_ready low → after TO_CYCLES cycles o_cpl_valid drops, code 3 pulses, and o_req_ready = 1. Assert rst during CPL → o_cpl_valid goes to 0 immediately.
